// File: rtl/bus_if_pkg.sv
// bus_if_pkg: shared state encoding and bus signalling constants for bus_master_if
package bus_if_pkg;
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        ACCESS = 2'd2,
        STALL  = 2'd3
    } state_e;
    localparam logic READ     = 1'b1;
    localparam logic WRITE    = 1'b0;
    localparam logic ENABLE_  = 1'b0;
    localparam logic DISABLE_ = 1'b1;
endpackage

// File: rtl/bus_if_wbuf.sv
// bus_if_wbuf: synchronous FIFO holding posted bus writes
// Ports: clk, reset (sync, active-high); push/push_data enqueue; pop dequeues;
//        head is the oldest entry; full/empty status.
module bus_if_wbuf #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic         full,
    output logic         empty
);
    localparam int PW = $clog2(DEPTH);
    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW:0]   count;
    logic          do_push, do_pop;
    assign full    = count == (PW+1)'(DEPTH);
    assign empty   = count == '0;
    assign head    = mem[rd_ptr];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    // DEPTH is a power of two, so the pointers wrap on their own
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop) rd_ptr <= rd_ptr + PW'(1);
            count <= count + (PW+1)'(do_push) - (PW+1)'(do_pop);
        end
    end
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end
endmodule

// File: rtl/bus_master_if.sv
// bus_master_if: CPU-side memory interface routing accesses to the scratch-pad or the system bus
// Ports: clk, reset (sync, active-high); stall, flush, busy (pipeline control);
//        addr, as_, rw, be, wr_data, rd_data (CPU access); spm_* (scratch-pad, same-cycle);
//        bus_req_, bus_grnt_, bus_as_, bus_addr, bus_rw, bus_wr_data, bus_be, bus_rdy_,
//        bus_rd_data (system bus handshake, registered fields).
// Define BUS_IF_POSTED_WR_EN to post bus writes into a WBUF_DEPTH-entry FIFO.
module bus_master_if
    import bus_if_pkg::*;
#(
    parameter int ADDR_W     = 30,
    parameter int DATA_W     = 32,
    parameter int IDX_W      = 3,
    parameter int SPM_IDX    = 1,
    parameter int WBUF_DEPTH = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                stall,
    input  logic                flush,
    output logic                busy,
    input  logic [ADDR_W-1:0]   addr,
    input  logic                as_,
    input  logic                rw,
    input  logic [DATA_W/8-1:0] be,
    input  logic [DATA_W-1:0]   wr_data,
    output logic [DATA_W-1:0]   rd_data,
    output logic [ADDR_W-1:0]   spm_addr,
    output logic                spm_as_,
    output logic                spm_rw,
    output logic [DATA_W-1:0]   spm_wr_data,
    output logic [DATA_W/8-1:0] spm_be,
    input  logic [DATA_W-1:0]   spm_rd_data,
    output logic                bus_req_,
    input  logic                bus_grnt_,
    output logic                bus_as_,
    output logic [ADDR_W-1:0]   bus_addr,
    output logic                bus_rw,
    output logic [DATA_W-1:0]   bus_wr_data,
    output logic [DATA_W/8-1:0] bus_be,
    input  logic                bus_rdy_,
    input  logic [DATA_W-1:0]   bus_rd_data
);
    state_e              state, state_nx;
    logic [DATA_W-1:0]   rd_buf;
    logic                acc, is_spm, bus_acc, rdy, done, launch, drain;
    assign acc         = as_ == ENABLE_ && !flush;
    assign is_spm      = addr[ADDR_W-1 -: IDX_W] == IDX_W'(SPM_IDX);
    assign bus_acc     = acc && !is_spm;
    assign rdy         = bus_rdy_ == ENABLE_;
    assign done        = state == ACCESS && rdy;
    assign spm_addr    = addr;
    assign spm_rw      = rw;
    assign spm_wr_data = wr_data;
    assign spm_be      = be;
    assign spm_as_     = (acc && is_spm && !stall) ? ENABLE_ : DISABLE_;
`ifdef BUS_IF_POSTED_WR_EN
    localparam int WB_W = ADDR_W + DATA_W/8 + DATA_W;
    logic            launch_wb, wb_push, wb_pop, wb_full, wb_empty;
    logic [WB_W-1:0] wb_head;
    bus_if_wbuf #(.W(WB_W), .DEPTH(WBUF_DEPTH)) u_wbuf (
        .clk       (clk),
        .reset     (reset),
        .push      (wb_push),
        .push_data ({addr, be, wr_data}),
        .pop       (wb_pop),
        .head      (wb_head),
        .full      (wb_full),
        .empty     (wb_empty)
    );
    // the head entry stays queued while on the bus, so it still counts toward full
    assign wb_pop = done && drain;
    always_ff @(posedge clk) begin
        if (reset) drain <= 1'b0;
        else if (launch_wb) drain <= 1'b1;
        else if (done) drain <= 1'b0;
    end
`else
    // without the FIFO every bus transaction belongs to the pipeline
    assign drain = WBUF_DEPTH < 0;
`endif
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else state <= state_nx;
    end
    always_comb begin
        state_nx = state;
        launch   = 1'b0;
        busy     = 1'b0;
        rd_data  = (spm_as_ == ENABLE_ && rw == READ) ? spm_rd_data : '0;
`ifdef BUS_IF_POSTED_WR_EN
        launch_wb = 1'b0;
        wb_push   = 1'b0;
        // writes keep posting while a drain owns the bus; reads wait for the FIFO to empty
        if (bus_acc && (state == IDLE || drain)) begin
            busy    = rw == READ || wb_full;
            wb_push = rw == WRITE && !wb_full && !stall;
        end
`endif
        case (state)
            IDLE: begin
`ifdef BUS_IF_POSTED_WR_EN
                launch_wb = !wb_empty;
                launch    = wb_empty && bus_acc && rw == READ;
                state_nx  = (launch || launch_wb) ? REQ : IDLE;
`else
                launch    = bus_acc;
                busy      = bus_acc;
                state_nx  = bus_acc ? REQ : IDLE;
`endif
            end
            REQ: begin
                busy     = busy || !drain;
                state_nx = bus_grnt_ == ENABLE_ ? ACCESS : REQ;
            end
            ACCESS: begin
                busy     = drain ? busy : !rdy;
                state_nx = !rdy ? ACCESS : (stall && !drain) ? STALL : IDLE;
                if (rdy && !drain && bus_rw == READ) rd_data = bus_rd_data;
            end
            STALL: begin
                rd_data  = rd_buf;
                state_nx = stall ? STALL : IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            bus_req_    <= DISABLE_;
            bus_as_     <= DISABLE_;
            bus_addr    <= '0;
            bus_rw      <= READ;
            bus_wr_data <= '0;
            bus_be      <= '0;
            rd_buf      <= '0;
        end else begin
            bus_as_ <= (state == REQ && bus_grnt_ == ENABLE_) ? ENABLE_ : DISABLE_;
            if (launch) begin
                bus_req_    <= ENABLE_;
                bus_addr    <= addr;
                bus_rw      <= rw;
                bus_wr_data <= wr_data;
                bus_be      <= be;
            end
`ifdef BUS_IF_POSTED_WR_EN
            if (launch_wb) begin
                bus_req_                           <= ENABLE_;
                bus_rw                             <= WRITE;
                {bus_addr, bus_be, bus_wr_data}    <= wb_head;
            end
`endif
            if (done) begin
                bus_req_    <= DISABLE_;
                bus_addr    <= '0;
                bus_rw      <= READ;
                bus_wr_data <= '0;
                bus_be      <= '0;
                if (!drain && bus_rw == READ) rd_buf <= bus_rd_data;
            end
        end
    end
endmodule

// File: tb/tb_bus_master_if.sv
// tb_bus_master_if: directed self-checking bench for bus_master_if
module tb_bus_master_if;
    logic        clk = 1'b0, reset = 1'b1, stall = 1'b0, flush = 1'b0;
    logic        as_ = 1'b1, rw = 1'b1, bus_grnt_ = 1'b1, bus_rdy_ = 1'b1;
    logic [29:0] addr = '0;
    logic [3:0]  be = '0;
    logic [31:0] wr_data = '0, spm_rd_data = '0, bus_rd_data = '0;
    logic        busy, spm_as_, spm_rw, bus_req_, bus_as_, bus_rw;
    logic [31:0] rd_data, spm_wr_data, bus_wr_data;
    logic [29:0] spm_addr, bus_addr;
    logic [3:0]  spm_be, bus_be;
    int          n_pass = 0, n_fail = 0, n_chk = 0;

    bus_master_if dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush), .busy(busy),
        .addr(addr), .as_(as_), .rw(rw), .be(be), .wr_data(wr_data), .rd_data(rd_data),
        .spm_addr(spm_addr), .spm_as_(spm_as_), .spm_rw(spm_rw), .spm_wr_data(spm_wr_data),
        .spm_be(spm_be), .spm_rd_data(spm_rd_data),
        .bus_req_(bus_req_), .bus_grnt_(bus_grnt_), .bus_as_(bus_as_), .bus_addr(bus_addr),
        .bus_rw(bus_rw), .bus_wr_data(bus_wr_data), .bus_be(bus_be), .bus_rdy_(bus_rdy_),
        .bus_rd_data(bus_rd_data)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

`ifdef BUS_IF_POSTED_WR_EN
    logic [29:0] wa  [5] = '{30'h1800_0000, 30'h1800_0001, 30'h2000_0002, 30'h1800_0003, 30'h2800_0004};
    logic [3:0]  wbe [5] = '{4'hF, 4'h1, 4'h3, 4'hC, 4'h8};
    logic [31:0] wd  [5] = '{32'hD000_0000, 32'hD000_0011, 32'hD000_0022, 32'hD000_0033, 32'hD000_0044};

    // wait (bounded) for the address strobe, check the transaction, answer with ready
    task automatic serve(input string tag, input logic [29:0] a, input logic [3:0] b,
                         input logic [31:0] d, input logic r);
        int n = 0;
        while (bus_as_ !== 1'b0 && n < 20) begin
            step();
            n++;
        end
        chk1({tag, "_as"}, bus_as_, 1'b0);
        chk({tag, "_addr"}, 32'(bus_addr), 32'(a));
        chk({tag, "_be"}, 32'(bus_be), 32'(b));
        chk({tag, "_data"}, bus_wr_data, d);
        chk1({tag, "_rw"}, bus_rw, r);
        bus_rdy_ = 1'b0;
        step();
        bus_rdy_ = 1'b1;
    endtask
`endif

    initial begin
        step();
        step();
        #1;
        chk1("rst_req", bus_req_, 1'b1);
        chk1("rst_as", bus_as_, 1'b1);
        chk("rst_addr", 32'(bus_addr), 32'h0);
        chk1("rst_rw", bus_rw, 1'b1);
        chk("rst_wdata", bus_wr_data, 32'h0);
        chk("rst_be", 32'(bus_be), 32'h0);
        chk1("rst_spm_as", spm_as_, 1'b1);
        chk1("rst_busy", busy, 1'b0);
        chk("rst_rdata", rd_data, 32'h0);
        reset = 1'b0;

        // scratch-pad read completes in the same cycle
        addr = 30'h0800_0010; as_ = 1'b0; rw = 1'b1; spm_rd_data = 32'hDEAD_BEEF;
        #1;
        chk("spm_rdata", rd_data, 32'hDEAD_BEEF);
        chk1("spm_as", spm_as_, 1'b0);
        chk1("spm_busy", busy, 1'b0);
        chk("spm_addr", 32'(spm_addr), 32'h0800_0010);
        stall = 1'b1;
        #1;
        chk1("spm_stall_as", spm_as_, 1'b1);
        chk1("spm_stall_busy", busy, 1'b0);
        stall = 1'b0; as_ = 1'b1;
        step();
        chk1("spm_no_bus", bus_req_, 1'b1);

        // bus read: grant at cycle 1, ready at cycle 4
        addr = 30'h1000_0004; as_ = 1'b0; rw = 1'b1;
        #1;
        chk1("rd_c0_busy", busy, 1'b1);
        step();
        chk1("rd_c1_req", bus_req_, 1'b0);
        chk("rd_c1_addr", 32'(bus_addr), 32'h1000_0004);
        chk1("rd_c1_busy", busy, 1'b1);
        chk1("rd_c1_as", bus_as_, 1'b1);
        bus_grnt_ = 1'b0;
        step();
        chk1("rd_c2_as", bus_as_, 1'b0);
        chk1("rd_c2_busy", busy, 1'b1);
        step();
        chk1("rd_c3_as", bus_as_, 1'b1);
        chk1("rd_c3_busy", busy, 1'b1);
        step();
        bus_rdy_ = 1'b0; bus_rd_data = 32'h1234_5678;
        #1;
        chk1("rd_c4_busy", busy, 1'b0);
        chk("rd_c4_rdata", rd_data, 32'h1234_5678);
        step();
        as_ = 1'b1; bus_rdy_ = 1'b1; bus_rd_data = '0;
        #1;
        chk1("rd_c5_req", bus_req_, 1'b1);
        chk("rd_c5_addr", 32'(bus_addr), 32'h0);

        // ready while stalled: rd_data holds the captured word until stall drops
        addr = 30'h1000_0008; as_ = 1'b0; rw = 1'b1;
        #1;
        chk1("st_c0_busy", busy, 1'b1);
        step();
        step();
        stall = 1'b1; bus_rdy_ = 1'b0; bus_rd_data = 32'hCAFE_F00D;
        #1;
        chk1("st_c2_busy", busy, 1'b0);
        chk("st_c2_rdata", rd_data, 32'hCAFE_F00D);
        step();
        bus_rdy_ = 1'b1; bus_rd_data = '0;
        #1;
        chk("st_c3_rdata", rd_data, 32'hCAFE_F00D);
        chk1("st_c3_req", bus_req_, 1'b1);
        chk1("st_c3_busy", busy, 1'b0);
        step();
        chk("st_c4_rdata", rd_data, 32'hCAFE_F00D);
        step();
        stall = 1'b0;
        #1;
        chk("st_c5_rdata", rd_data, 32'hCAFE_F00D);
        step();
        as_ = 1'b1;
        #1;
        chk("st_c6_rdata", rd_data, 32'h0);
        chk1("st_c6_busy", busy, 1'b0);

        // flush blocks a new access
        addr = 30'h1000_0200; as_ = 1'b0; rw = 1'b1; flush = 1'b1;
        #1;
        chk1("fl_busy", busy, 1'b0);
        step();
        chk1("fl_req", bus_req_, 1'b1);
        addr = 30'h0800_0000;
        #1;
        chk1("fl_spm_as", spm_as_, 1'b1);
        flush = 1'b0; as_ = 1'b1;
        step();

        // reset in ACCESS drops the request and returns to IDLE
        addr = 30'h1000_0300; as_ = 1'b0; rw = 1'b1;
        step();
        step();
        chk1("rs_access_as", bus_as_, 1'b0);
        reset = 1'b1;
        step();
        chk1("rs_req", bus_req_, 1'b1);
        chk1("rs_as", bus_as_, 1'b1);
        chk("rs_addr", 32'(bus_addr), 32'h0);
        reset = 1'b0;
        #1;
        chk1("rs_idle_busy", busy, 1'b1);
        step();
        chk1("rs_relaunch_req", bus_req_, 1'b0);
        chk("rs_relaunch_addr", 32'(bus_addr), 32'h1000_0300);
        step();
        bus_rdy_ = 1'b0;
        step();
        bus_rdy_ = 1'b1; as_ = 1'b1;
        step();

`ifdef BUS_IF_POSTED_WR_EN
        // five back-to-back posted writes, grant withheld: fifth finds the FIFO full
        bus_grnt_ = 1'b1;
        for (int k = 0; k < 5; k++) begin
            as_ = 1'b0; rw = 1'b0; addr = wa[k]; be = wbe[k]; wr_data = wd[k];
            #1;
            chk1($sformatf("pw_busy%0d", k + 1), busy, k == 4);
            if (k < 4) step();
        end
        bus_grnt_ = 1'b0;
        step();
        chk1("pw1_as", bus_as_, 1'b0);
        chk("pw1_addr", 32'(bus_addr), 32'(wa[0]));
        chk("pw1_be", 32'(bus_be), 32'(wbe[0]));
        chk("pw1_data", bus_wr_data, wd[0]);
        bus_rdy_ = 1'b0;
        #1;
        chk1("pw5_full_busy", busy, 1'b1);
        step();
        bus_rdy_ = 1'b1;
        #1;
        chk1("pw5_drained_busy", busy, 1'b0);
        step();
        as_ = 1'b1;
        for (int k = 1; k < 5; k++) serve($sformatf("pw%0d", k + 1), wa[k], wbe[k], wd[k], 1'b0);

        // queued write must reach the bus before a following read
        as_ = 1'b0; rw = 1'b0; addr = 30'h2000_0040; be = 4'h6; wr_data = 32'h0BAD_F00D;
        #1;
        chk1("ord_c0_busy", busy, 1'b0);
        step();
        rw = 1'b1; addr = 30'h1000_0100;
        #1;
        chk1("ord_c1_busy", busy, 1'b1);
        step();
        chk1("ord_c2_busy", busy, 1'b1);
        chk1("ord_c2_rw", bus_rw, 1'b0);
        chk("ord_c2_addr", 32'(bus_addr), 32'h2000_0040);
        step();
        chk1("ord_c3_as", bus_as_, 1'b0);
        chk("ord_c3_be", 32'(bus_be), 32'h6);
        bus_rdy_ = 1'b0;
        #1;
        chk1("ord_c3_busy", busy, 1'b1);
        step();
        bus_rdy_ = 1'b1;
        #1;
        chk1("ord_c4_busy", busy, 1'b1);
        step();
        chk1("ord_c5_req", bus_req_, 1'b0);
        chk1("ord_c5_rw", bus_rw, 1'b1);
        chk("ord_c5_addr", 32'(bus_addr), 32'h1000_0100);
        step();
        chk1("ord_c6_as", bus_as_, 1'b0);
        bus_rdy_ = 1'b0; bus_rd_data = 32'h5A5A_1234;
        #1;
        chk1("ord_c6_busy", busy, 1'b0);
        chk("ord_c6_rdata", rd_data, 32'h5A5A_1234);
        step();
        bus_rdy_ = 1'b1; as_ = 1'b1;
        #1;
        chk1("ord_c7_req", bus_req_, 1'b1);
`else
        // without posting, a bus write blocks until ready
        addr = 30'h1800_0020; as_ = 1'b0; rw = 1'b0; be = 4'h3; wr_data = 32'hA5A5_0001;
        #1;
        chk1("bw_c0_busy", busy, 1'b1);
        step();
        chk1("bw_c1_req", bus_req_, 1'b0);
        chk1("bw_c1_rw", bus_rw, 1'b0);
        chk("bw_c1_be", 32'(bus_be), 32'h3);
        chk("bw_c1_data", bus_wr_data, 32'hA5A5_0001);
        chk1("bw_c1_busy", busy, 1'b1);
        step();
        chk1("bw_c2_as", bus_as_, 1'b0);
        chk1("bw_c2_busy_wait", busy, 1'b1);
        bus_rdy_ = 1'b0;
        #1;
        chk1("bw_c2_busy", busy, 1'b0);
        step();
        bus_rdy_ = 1'b1; as_ = 1'b1;
        #1;
        chk1("bw_c3_req", bus_req_, 1'b1);
        chk("bw_c3_be", 32'(bus_be), 32'h0);
        chk("bw_c3_data", bus_wr_data, 32'h0);
`endif
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
